// File: rtl/stream_rr_mux.sv
// stream_rr_mux: fair round-robin merge of N_INP valid/ready streams onto one output stream.
// Define STREAM_RR_MUX_OUT_REG_EN to add a one-entry output register (1-cycle valid/data latency).
module stream_rr_mux #(
  parameter int N_INP      = 2,
  parameter int DATA_WIDTH = 8,
  parameter bit LOCK_IN    = 1'b1,
  parameter int LOG_N_INP  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_INP-1:0]                    inp_valid_i,
  output logic [N_INP-1:0]                    inp_ready_o,
  input  logic [N_INP-1:0][DATA_WIDTH-1:0]    inp_data_i,
  output logic                                oup_valid_o,
  input  logic                                oup_ready_i,
  output logic [DATA_WIDTH-1:0]               oup_data_o,
  output logic [LOG_N_INP-1:0]                oup_idx_o
);
  localparam logic [LOG_N_INP-1:0] LAST_IDX = LOG_N_INP'(N_INP - 1);

  logic [LOG_N_INP-1:0]  rr_q;
  logic [LOG_N_INP-1:0]  lidx_q;
  logic                  lock_q;
  logic [LOG_N_INP-1:0]  rr_idx;
  logic                  rr_found;
  logic [LOG_N_INP-1:0]  gnt;
  logic                  gnt_any;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] arb_data;
  logic                  path_ready;
  logic                  handshake;

  // First pass covers rr_q..N_INP-1, second pass the wrapped part 0..rr_q-1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_q;
    for (int i = 0; i < N_INP; i++) begin
      if (!rr_found && inp_valid_i[i] && (i >= int'(rr_q))) begin
        rr_found = 1'b1;
        rr_idx   = LOG_N_INP'(i);
      end
    end
    for (int i = 0; i < N_INP; i++) begin
      if (!rr_found && inp_valid_i[i]) begin
        rr_found = 1'b1;
        rr_idx   = LOG_N_INP'(i);
      end
    end
  end

  assign gnt     = lock_q ? lidx_q : rr_idx;
  assign gnt_any = lock_q || rr_found;

  always_comb begin
    arb_valid = 1'b0;
    arb_data  = '0;
    for (int i = 0; i < N_INP; i++) begin
      if (gnt == LOG_N_INP'(i)) begin
        arb_valid = inp_valid_i[i];
        arb_data  = inp_data_i[i];
      end
    end
    arb_valid = arb_valid && gnt_any && rst_ni;
  end

  generate
    for (genvar gi = 0; gi < N_INP; gi++) begin : g_ready
      assign inp_ready_o[gi] = rst_ni && gnt_any && (gnt == LOG_N_INP'(gi)) && path_ready;
    end
  endgenerate

  assign handshake = arb_valid && path_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (handshake) begin
      rr_q   <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
      lock_q <= 1'b0;
    end else if (lock_q && !arb_valid) begin
      // Locked source withdrew its beat: release and arbitrate afresh.
      lock_q <= 1'b0;
    end else if (LOCK_IN && arb_valid) begin
      lock_q <= 1'b1;
      lidx_q <= gnt;
    end
  end

`ifdef STREAM_RR_MUX_OUT_REG_EN
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LOG_N_INP-1:0]  idx_q;

  // Register accepts whenever it is empty or being drained this cycle.
  assign path_ready = !valid_q || oup_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (path_ready) begin
      valid_q <= arb_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (path_ready) begin
      data_q <= arb_data;
      idx_q  <= gnt;
    end
  end

  assign oup_valid_o = valid_q;
  assign oup_data_o  = data_q;
  assign oup_idx_o   = idx_q;
`else
  assign path_ready  = oup_ready_i;
  assign oup_valid_o = arb_valid;
  assign oup_data_o  = arb_data;
  assign oup_idx_o   = gnt;
`endif

`ifndef SYNTHESIS
  // A locked source must hold valid until its beat is taken.
  locked_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> arb_valid);
`endif

endmodule

// File: tb/tb_stream_rr_mux.sv
// tb_stream_rr_mux: directed and randomized checks of stream_rr_mux (N_INP=4 and N_INP=3, LOCK_IN=1).
module tb_stream_rr_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0]      v4, ir4;
  logic [3:0][7:0] d4;
  logic            rdy4, ov4;
  logic [7:0]      od4;
  logic [1:0]      oi4;
  logic [2:0]      v3, ir3;
  logic [2:0][7:0] d3;
  logic            rdy3, ov3;
  logic [7:0]      od3;
  logic [1:0]      oi3;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model of the 4-input instance: priority pointer and held grant.
  int m_ptr;
  bit m_lock;
  int m_lidx;

  stream_rr_mux #(.N_INP(4), .DATA_WIDTH(8), .LOCK_IN(1'b1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .inp_valid_i(v4), .inp_ready_o(ir4), .inp_data_i(d4),
    .oup_valid_o(ov4), .oup_ready_i(rdy4), .oup_data_o(od4), .oup_idx_o(oi4)
  );

  stream_rr_mux #(.N_INP(3), .DATA_WIDTH(8), .LOCK_IN(1'b1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .inp_valid_i(v3), .inp_ready_o(ir3), .inp_data_i(d3),
    .oup_valid_o(ov3), .oup_ready_i(rdy3), .oup_data_o(od3), .oup_idx_o(oi3)
  );

  function automatic int model_grant(input logic [3:0] v);
    if (m_lock) return m_lidx;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic rdy, input int g);
    if (g < 0) return;
    if (!v[2'(g)]) m_lock = 1'b0;
    else if (rdy) begin
      m_ptr  = (g + 1) % 4;
      m_lock = 1'b0;
    end else begin
      m_lock = 1'b1;
      m_lidx = g;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v4 = '0; v3 = '0; d4 = '0; d3 = '0; rdy4 = 1'b0; rdy3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_lock = 1'b0;
    m_lidx = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v4 = 4'hF; v3 = 3'h7; rdy4 = 1'b1; rdy3 = 1'b1;
    #1;
    n_checks += 4;
    if (ov4 !== 1'b0) begin n_fails++; $display("FAIL reset_valid4 got %b expected 0", ov4); end
    if (ir4 !== 4'h0) begin n_fails++; $display("FAIL reset_ready4 got %b expected 0000", ir4); end
    if (ov3 !== 1'b0) begin n_fails++; $display("FAIL reset_valid3 got %b expected 0", ov3); end
    if (ir3 !== 3'h0) begin n_fails++; $display("FAIL reset_ready3 got %b expected 000", ir3); end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    v4 = 4'hF; rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 8'h40 + 8'(i);
    for (int c = 0; c < 8; c++) begin
      int e;
      e = c % 4;
      #1;
      n_checks += 3;
      if (oi4 !== 2'(e) || ov4 !== 1'b1) begin
        n_fails++; $display("FAIL rr_idx beat %0d got idx %0d valid %b expected idx %0d valid 1", c, oi4, ov4, e);
      end
      if (od4 !== 8'h40 + 8'(e)) begin
        n_fails++; $display("FAIL rr_data beat %0d got %02h expected %02h", c, od4, 8'h40 + 8'(e));
      end
      if (ir4 !== (4'b0001 << e)) begin
        n_fails++; $display("FAIL rr_ready beat %0d got %b expected %b", c, ir4, 4'b0001 << e);
      end
      $display("rr beat %0d idx=%0d data=%02h", c, oi4, od4);
      @(negedge clk);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    v4 = 4'b0010; rdy4 = 1'b1;
    #1;
    n_checks++;
    if (oi4 !== 2'd1) begin n_fails++; $display("FAIL sparse_setup got idx %0d expected 1", oi4); end
    @(negedge clk);
    v4 = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      int e;
      e = (c % 2 == 0) ? 3 : 1;
      #1;
      n_checks += 2;
      if (oi4 !== 2'(e)) begin n_fails++; $display("FAIL sparse_idx beat %0d got %0d expected %0d", c, oi4, e); end
      if ((ir4 & 4'b0101) !== 4'b0000) begin
        n_fails++; $display("FAIL sparse_ready beat %0d got %b expected inputs 0/2 low", c, ir4);
      end
      $display("sparse beat %0d idx=%0d", c, oi4);
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    for (int variant = 0; variant < 2; variant++) begin
      do_reset();
      v4 = 4'b0010; rdy4 = 1'b1;
      #1;
      @(negedge clk);
      v4 = 4'b0100; d4[2] = 8'hC2; rdy4 = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (c == 1) begin v4 = 4'b0101; d4[0] = 8'h0E; end
        #1;
        n_checks += 3;
        if (oi4 !== 2'd2 || ov4 !== 1'b1) begin
          n_fails++; $display("FAIL lock_idx cycle %0d got idx %0d valid %b expected idx 2 valid 1", c, oi4, ov4);
        end
        if (od4 !== 8'hC2) begin n_fails++; $display("FAIL lock_data cycle %0d got %02h expected c2", c, od4); end
        if (ir4 !== 4'b0000) begin n_fails++; $display("FAIL lock_ready cycle %0d got %b expected 0000", c, ir4); end
        @(negedge clk);
      end
      rdy4 = 1'b1;
      v4 = (variant == 0) ? 4'b1101 : 4'b0101;
      #1;
      n_checks++;
      if (ir4 !== 4'b0100) begin n_fails++; $display("FAIL lock_release got ready %b expected 0100", ir4); end
      $display("lock beat idx=%0d data=%02h", oi4, od4);
      @(negedge clk);
      v4[2] = 1'b0;
      #1;
      n_checks++;
      if (oi4 !== ((variant == 0) ? 2'd3 : 2'd0)) begin
        n_fails++; $display("FAIL lock_next variant %0d got idx %0d expected %0d", variant, oi4, (variant == 0) ? 3 : 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    v3 = 3'h7; rdy3 = 1'b1;
    for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
    for (int c = 0; c < 7; c++) begin
      int e;
      e = c % 3;
      #1;
      n_checks += 2;
      if (oi3 !== 2'(e) || ov3 !== 1'b1) begin
        n_fails++; $display("FAIL wrap_idx beat %0d got idx %0d valid %b expected idx %0d valid 1", c, oi3, ov3, e);
      end
      if (od3 !== 8'h30 + 8'(e)) begin n_fails++; $display("FAIL wrap_data beat %0d got %02h expected %02h", c, od3, 8'h30 + 8'(e)); end
      $display("wrap beat %0d idx=%0d", c, oi3);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    v4 = 4'b0010; rdy4 = 1'b1;
    #1;
    @(negedge clk);
    v4 = 4'b0100; rdy4 = 1'b0;
    @(negedge clk);
    v4 = 4'b0101;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (ov4 !== 1'b0) begin n_fails++; $display("FAIL midrst_valid got %b expected 0", ov4); end
    if (ir4 !== 4'b0000) begin n_fails++; $display("FAIL midrst_ready got %b expected 0000", ir4); end
    @(negedge clk);
    rst_n = 1'b1; m_ptr = 0; m_lock = 1'b0;
    v4 = 4'hF; rdy4 = 1'b1;
    #1;
    n_checks += 2;
    if (oi4 !== 2'd0) begin n_fails++; $display("FAIL midrst_first got idx %0d expected 0", oi4); end
    if (ir4 !== 4'b0001) begin n_fails++; $display("FAIL midrst_ready1 got %b expected 0001", ir4); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] acc;
    do_reset();
    acc = '0;
    for (int c = 0; c < 400; c++) begin
      int g;
      bit ev;
      for (int i = 0; i < 4; i++) begin
        if (!v4[i] || acc[i]) begin
          v4[i] = 1'($urandom_range(0, 1));
          d4[i] = 8'($urandom);
        end
      end
      rdy4 = ($urandom % 4) != 0;
      #1;
      g  = model_grant(v4);
      ev = (g >= 0) && v4[2'(g)];
      n_checks += 2;
      if (ov4 !== ev) begin n_fails++; $display("FAIL rand_valid cycle %0d got %b expected %b", c, ov4, ev); end
      if (ir4 !== ((g >= 0 && rdy4) ? (4'b0001 << g) : 4'b0000)) begin
        n_fails++; $display("FAIL rand_ready cycle %0d got %b expected grant %0d rdy %b", c, ir4, g, rdy4);
      end
      if (ev) begin
        n_checks++;
        if (oi4 !== 2'(g) || od4 !== d4[2'(g)]) begin
          n_fails++; $display("FAIL rand_beat cycle %0d got idx %0d data %02h expected idx %0d data %02h", c, oi4, od4, g, d4[2'(g)]);
        end
      end
      acc = (ev && rdy4) ? (4'b0001 << g) : 4'b0000;
      if (ev && rdy4) $display("rand beat cycle %0d idx=%0d data=%02h", c, g, d4[2'(g)]);
      model_step(v4, rdy4, g);
      @(negedge clk);
    end
  endtask

`ifdef STREAM_RR_MUX_OUT_REG_EN
  task automatic test_out_reg();
    do_reset();
    v4 = 4'b0010; d4[1] = 8'hA5; rdy4 = 1'b1;
    #1;
    n_checks++;
    if (ov4 !== 1'b0) begin n_fails++; $display("FAIL oreg_latency got valid %b expected 0", ov4); end
    @(negedge clk);
    v4 = 4'b0000;
    #1;
    n_checks++;
    if (ov4 !== 1'b1 || od4 !== 8'hA5 || oi4 !== 2'd1) begin
      n_fails++; $display("FAIL oreg_data got valid %b data %02h idx %0d expected 1 a5 1", ov4, od4, oi4);
    end
    v4 = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (ov4 !== 1'b1 || oi4 !== 2'((2 + c) % 4)) begin
        n_fails++; $display("FAIL oreg_b2b beat %0d got valid %b idx %0d expected 1 %0d", c, ov4, oi4, (2 + c) % 4);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    v4 = '0; v3 = '0; d4 = '0; d3 = '0; rdy4 = 1'b0; rdy3 = 1'b0;
    m_ptr = 0; m_lock = 1'b0; m_lidx = 0;
    test_reset();
`ifdef STREAM_RR_MUX_OUT_REG_EN
    test_out_reg();
`else
    test_round_robin();
    test_sparse();
    test_lock();
    test_wrap();
    test_reset_mid();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
